fifo_sync_fwft_stat: RTL and testbench

First-word-fall-through synchronous FIFO: the parametrised successor to our basic sync FIFO, for datapath buffering where producer and consumer share one clock. Beyond the basic FIFO it adds:
- programmable almost-full and almost-empty flags
- writes accepted while full when a read happens in the same cycle
- a synchronous flush
- sticky overflow and underflow error flags
- a high-watermark statistic for sizing buffers in system tests

---
 rtl/fifo_sync_fwft_stat.sv | 144 ++++++++++++++
 tb/tb_fifo_sync_fwft_stat.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_fwft_stat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fifo_sync_fwft_stat                                            |
// | Purpose : Single-clock first-word-fall-through FIFO with programmable     |
// |           almost-full/almost-empty flags, write-while-full when a read    |
// |           is accepted in the same cycle, synchronous flush, sticky        |
// |           overflow/underflow flags and a high-watermark statistic.        |
// | Ports   : clk, rst_n     - clock (rising edge), async active-low reset    |
// |           flush          - synchronous clear of contents                  |
// |           wr_ena, wr_dat - write request and data                         |
// |           wr_full/afull  - count == DEPTH / count >= AFULL_LVL            |
// |           rd_ena         - pop request                                    |
// |           rd_dat         - head word (valid while rd_empty = 0)           |
// |           rd_empty/aempty- count == 0 / count <= AEMPTY_LVL               |
// |           dat_cnt        - current word count 0..DEPTH                    |
// |           max_cnt        - highest dat_cnt since reset or stat_clr        |
// |           ovf, udf       - sticky refused-write / read-while-empty flags  |
// |           stat_clr       - synchronous clear of ovf, udf and max_cnt      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_sync_fwft_stat #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int AFULL_LVL  = 252,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_ena,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic                  wr_full,
  output logic                  wr_afull,
  input  logic                  rd_ena,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output logic                  rd_empty,
  output logic                  rd_aempty,
  output logic [ADDR_WIDTH:0]   dat_cnt,
  output logic [ADDR_WIDTH:0]   max_cnt,
  output logic                  ovf,
  output logic                  udf,
  input  logic                  stat_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] c_afull_lvl  = AFULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] c_aempty_lvl = AEMPTY_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] c_one        = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Storage: deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] r_wrptr;
  logic [ADDR_WIDTH:0] r_rdptr;
  logic [ADDR_WIDTH:0] r_dat_cnt;
  logic [ADDR_WIDTH:0] r_max_cnt;
  logic                r_ovf;
  logic                r_udf;

  logic                w_empty;
  logic                w_full;
  logic                w_rd_acc;
  logic                w_wr_acc;
  logic                w_ovf_set;
  logic                w_udf_set;
  logic [ADDR_WIDTH:0] w_cnt_nxt;

  // Extra MSB on the pointers separates full from empty when the
  // address bits coincide.
  assign w_empty = (r_wrptr == r_rdptr);
  assign w_full  = (r_wrptr[ADDR_WIDTH-1:0] == r_rdptr[ADDR_WIDTH-1:0]) &&
                   (r_wrptr[ADDR_WIDTH] != r_rdptr[ADDR_WIDTH]);

  // A read frees a slot in the same cycle, so a full FIFO can still take a
  // write when it is popped. An empty FIFO never bypasses write to read.
  assign w_rd_acc = rd_ena & ~w_empty;
  assign w_wr_acc = wr_ena & (~w_full | w_rd_acc);

  // Flush swallows the cycle's requests, including their error events.
  assign w_ovf_set = ~flush & wr_ena & ~w_wr_acc;
  assign w_udf_set = ~flush & rd_ena & w_empty;

  always_comb begin
    w_cnt_nxt = r_dat_cnt;
    if (flush) begin
      w_cnt_nxt = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nxt = r_dat_cnt + c_one;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_cnt_nxt = r_dat_cnt - c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrptr   <= '0;
      r_rdptr   <= '0;
      r_dat_cnt <= '0;
      r_max_cnt <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (flush) begin
        r_wrptr <= '0;
        r_rdptr <= '0;
      end else begin
        if (w_wr_acc) r_wrptr <= r_wrptr + c_one;
        if (w_rd_acc) r_rdptr <= r_rdptr + c_one;
      end
      r_dat_cnt <= w_cnt_nxt;

      // stat_clr restarts the watermark from the post-edge count; a set
      // event coinciding with the clear still wins for the sticky flags.
      if (stat_clr) begin
        r_max_cnt <= w_cnt_nxt;
        r_ovf     <= w_ovf_set;
        r_udf     <= w_udf_set;
      end else begin
        if (w_cnt_nxt > r_max_cnt) r_max_cnt <= w_cnt_nxt;
        if (w_ovf_set) r_ovf <= 1'b1;
        if (w_udf_set) r_udf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !flush) begin
      mem[r_wrptr[ADDR_WIDTH-1:0]] <= wr_dat;
    end
  end

  assign rd_dat    = mem[r_rdptr[ADDR_WIDTH-1:0]];
  assign rd_empty  = w_empty;
  assign wr_full   = w_full;
  assign wr_afull  = (r_dat_cnt >= c_afull_lvl);
  assign rd_aempty = (r_dat_cnt <= c_aempty_lvl);
  assign dat_cnt   = r_dat_cnt;
  assign max_cnt   = r_max_cnt;
  assign ovf       = r_ovf;
  assign udf       = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_fwft_stat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_fifo_sync_fwft_stat                                         |
// | Purpose : Self-checking bench for fifo_sync_fwft_stat; directed scenarios |
// |           plus randomized traffic against a queue-based reference model.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fifo_sync_fwft_stat;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AFL   = 252;
  localparam int AEL   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_ena;
  logic [DW-1:0] wr_dat;
  logic          wr_full;
  logic          wr_afull;
  logic          rd_ena;
  logic [DW-1:0] rd_dat;
  logic          rd_empty;
  logic          rd_aempty;
  logic [AW:0]   dat_cnt;
  logic [AW:0]   max_cnt;
  logic          ovf;
  logic          udf;
  logic          stat_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as a queue, statistics as plain values.
  logic [DW-1:0] q[$];
  int            m_max = 0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  fifo_sync_fwft_stat #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_full(wr_full), .wr_afull(wr_afull),
    .rd_ena(rd_ena), .rd_dat(rd_dat), .rd_empty(rd_empty), .rd_aempty(rd_aempty),
    .dat_cnt(dat_cnt), .max_cnt(max_cnt), .ovf(ovf), .udf(udf),
    .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle of stimulus; the model is advanced with the rules of the
  // FIFO stated in terms of the queue, then outputs are sampled 1 ns later.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic fl, input logic sc);
    logic was_empty, was_full, racc, wacc, oset, uset;
    wr_ena = w; rd_ena = r; wr_dat = d; flush = fl; stat_clr = sc;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    racc = r && !was_empty;
    wacc = w && (!was_full || racc);
    oset = !fl && w && !wacc;
    uset = !fl && r && was_empty;
    if (fl) q.delete();
    else begin
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
    end
    if (sc) begin
      m_max = q.size(); m_ovf = oset; m_udf = uset;
    end else begin
      if (q.size() > m_max) m_max = q.size();
      m_ovf = m_ovf | oset;
      m_udf = m_udf | uset;
    end
    @(posedge clk);
    #1;
    wr_ena = 1'b0; rd_ena = 1'b0; flush = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rd_empty: got %b exp 1", rd_empty); end
    n_checks++; if (rd_aempty !== 1'b1) begin n_fail++; $display("FAIL reset_rd_aempty: got %b exp 1", rd_aempty); end
    n_checks++; if (wr_full !== 1'b0) begin n_fail++; $display("FAIL reset_wr_full: got %b exp 0", wr_full); end
    n_checks++; if (wr_afull !== 1'b0) begin n_fail++; $display("FAIL reset_wr_afull: got %b exp 0", wr_afull); end
    n_checks++; if (dat_cnt !== 9'd0) begin n_fail++; $display("FAIL reset_dat_cnt: got %0d exp 0", dat_cnt); end
    n_checks++; if (max_cnt !== 9'd0) begin n_fail++; $display("FAIL reset_max_cnt: got %0d exp 0", max_cnt); end
    n_checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_udf: got %b%b exp 00", ovf, udf); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
      n_checks++; if (dat_cnt !== 9'(i + 1)) begin n_fail++; $display("FAIL fill_dat_cnt[%0d]: got %0d exp %0d", i, dat_cnt, i + 1); end
      n_checks++; if (rd_dat !== 16'h0000) begin n_fail++; $display("FAIL fill_rd_dat[%0d]: got %h exp 0000", i, rd_dat); end
      n_checks++; if (wr_afull !== ((i + 1) >= 252)) begin n_fail++; $display("FAIL fill_wr_afull[%0d]: got %b", i, wr_afull); end
      n_checks++; if (wr_full !== ((i + 1) == 256)) begin n_fail++; $display("FAIL fill_wr_full[%0d]: got %b", i, wr_full); end
      n_checks++; if (rd_empty !== 1'b0) begin n_fail++; $display("FAIL fill_rd_empty[%0d]: got %b exp 0", i, rd_empty); end
    end
    n_checks++; if (max_cnt !== 9'd256) begin n_fail++; $display("FAIL fill_max_cnt: got %0d exp 256", max_cnt); end
  endtask

  task automatic test_overflow_drain();
    cycle(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b exp 1", ovf); end
    n_checks++; if (dat_cnt !== 9'd256) begin n_fail++; $display("FAIL ovf_dat_cnt: got %0d exp 256", dat_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (rd_dat !== DW'(i)) begin n_fail++; $display("FAIL drain_rd_dat[%0d]: got %h exp %h", i, rd_dat, DW'(i)); end
      cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      n_checks++; if (dat_cnt !== 9'(255 - i)) begin n_fail++; $display("FAIL drain_dat_cnt[%0d]: got %0d exp %0d", i, dat_cnt, 255 - i); end
      n_checks++; if (rd_aempty !== ((255 - i) <= 4)) begin n_fail++; $display("FAIL drain_rd_aempty[%0d]: got %b", i, rd_aempty); end
      n_checks++; if (rd_empty !== (i == 255)) begin n_fail++; $display("FAIL drain_rd_empty[%0d]: got %b", i, rd_empty); end
    end
    n_checks++; if (ovf !== 1'b1 || udf !== 1'b0) begin n_fail++; $display("FAIL drain_flags: got ovf=%b udf=%b exp 1 0", ovf, udf); end
  endtask

  task automatic test_full_simul();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL simul_clr_ovf: got %b exp 0", ovf); end
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0);
    n_checks++; if (dat_cnt !== 9'd256) begin n_fail++; $display("FAIL full_simul_cnt: got %0d exp 256", dat_cnt); end
    n_checks++; if (wr_full !== 1'b1) begin n_fail++; $display("FAIL full_simul_full: got %b exp 1", wr_full); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_simul_ovf: got %b exp 0", ovf); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      n_checks++; if (rd_dat !== q[0]) begin n_fail++; $display("FAIL full_simul_rd[%0d]: got %h exp %h", i, rd_dat, q[0]); end
      cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
    n_checks++; if (rd_dat !== 16'hA5A5) begin n_fail++; $display("FAIL full_simul_last: got %h exp a5a5", rd_dat); end
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    n_checks++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL full_simul_empty: got %b exp 1", rd_empty); end
  endtask

  task automatic test_empty_simul();
    cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    n_checks++; if (udf !== 1'b1) begin n_fail++; $display("FAIL empty_simul_udf: got %b exp 1", udf); end
    n_checks++; if (dat_cnt !== 9'd1) begin n_fail++; $display("FAIL empty_simul_cnt: got %0d exp 1", dat_cnt); end
    n_checks++; if (rd_dat !== 16'h1234 || rd_empty !== 1'b0) begin n_fail++; $display("FAIL empty_simul_rd: got %h/%b exp 1234/0", rd_dat, rd_empty); end
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (max_cnt !== 9'd0 || udf !== 1'b0) begin n_fail++; $display("FAIL flush_pre_clr: got max=%0d udf=%b exp 0 0", max_cnt, udf); end
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0);
    n_checks++; if (dat_cnt !== 9'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d exp 0", dat_cnt); end
    n_checks++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b exp 1", rd_empty); end
    n_checks++; if (max_cnt !== 9'd100) begin n_fail++; $display("FAIL flush_max_cnt: got %0d exp 100", max_cnt); end
    // Read while empty during flush must not flag underflow.
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b0);
    n_checks++; if (udf !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL flush_no_err: got ovf=%b udf=%b exp 0 0", ovf, udf); end
    // Underflow coinciding with stat_clr: the set event wins.
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b1);
    n_checks++; if (udf !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set_udf: got %b exp 1", udf); end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (max_cnt !== 9'd0 || ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL stat_clr: got max=%0d ovf=%b udf=%b exp 0 0 0", max_cnt, ovf, udf); end
  endtask

  task automatic test_random();
    int pw;
    for (int i = 0; i < 1000; i++) begin
      pw = ((i / 250) % 2 == 0) ? 75 : 30;
      cycle(($urandom % 100) < pw, ($urandom % 100) < (100 - pw + 10), DW'($urandom),
            ($urandom % 200) == 0, ($urandom % 100) == 0);
      n_checks++; if (dat_cnt !== 9'(q.size())) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d exp %0d", i, dat_cnt, q.size()); end
      n_checks++; if (q.size() > 0 && rd_dat !== q[0]) begin n_fail++; $display("FAIL rnd_rd_dat[%0d]: got %h exp %h", i, rd_dat, q[0]); end
      n_checks++; if (rd_empty !== (q.size() == 0) || wr_full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_empty_full[%0d]: got %b%b", i, rd_empty, wr_full); end
      n_checks++; if (wr_afull !== (q.size() >= AFL) || rd_aempty !== (q.size() <= AEL)) begin n_fail++; $display("FAIL rnd_levels[%0d]: got afull=%b aempty=%b", i, wr_afull, rd_aempty); end
      n_checks++; if (max_cnt !== 9'(m_max)) begin n_fail++; $display("FAIL rnd_max_cnt[%0d]: got %0d exp %0d", i, max_cnt, m_max); end
      n_checks++; if (ovf !== m_ovf || udf !== m_udf) begin n_fail++; $display("FAIL rnd_err[%0d]: got ovf=%b udf=%b exp %b %b", i, ovf, udf, m_ovf, m_udf); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    wr_ena = 1'b1; rd_ena = 1'b1; wr_dat = 16'h5555;
    #3 rst_n = 1'b0;
    #1;
    q.delete(); m_max = 0; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    #2 rst_n = 1'b1;
    wr_ena = 1'b0; rd_ena = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (dat_cnt !== 9'd0 || rd_empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got cnt=%0d empty=%b exp 0 1", dat_cnt, rd_empty); end
    cycle(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    n_checks++; if (rd_dat !== 16'hBEEF || dat_cnt !== 9'd1) begin n_fail++; $display("FAIL post_reset_write: got %h/%0d exp beef/1", rd_dat, dat_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_ena = 1'b0; rd_ena = 1'b0;
    wr_dat = '0; stat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    test_fill();
    test_overflow_drain();
    test_full_simul();
    test_empty_simul();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
